// File: rtl/sdr_qsram_banked.sv
// Banked single-port SRAM with a one-cycle registered read and a bank-rotating refresh engine.
// Only the bank that is currently in refresh stalls. All other banks keep full throughput.
module sdr_qsram_banked #(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH       = 16,
  parameter int BANK_BITS        = 2,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Enable,
  input  logic                  Read,
  input  logic                  Write,
  input  logic                  Refresh,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  ReadValid,
  output logic                  Ready,
  output logic                  Refreshing,
  output logic [BANK_BITS-1:0]  RefreshBank,
  output logic                  CmdError
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);

  typedef enum logic {IDLE, REFRESH} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       icnt, icnt_nxt;
  logic [RC_W-1:0]        rcnt, rcnt_nxt;
  logic                   pending, pending_nxt;
  logic [BANK_BITS-1:0]   bank, bank_nxt;

  logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];
  logic [BANK_BITS-1:0]   cmd_bank;
  logic                   accept, do_wr, do_rd, illegal;

  logic [DATA_WIDTH-1:0]  rdata_p1;
  logic                   vld_p1;
  logic                   err_p1;

  assign cmd_bank    = Address[ADDR_WIDTH-1 -: BANK_BITS];
  assign Refreshing  = (state == REFRESH);
  assign RefreshBank = bank;
  assign Ready       = !(Refreshing && (cmd_bank == bank));
  assign accept      = Enable && Ready;
  assign do_wr       = accept && Write;
  assign do_rd       = accept && Read && !Write;
  assign illegal     = accept && (Read == Write);

  // Refresh requests that arrive while one is pending or running collapse into a single pending flag.
  always_comb begin
    state_nxt   = state;
    icnt_nxt    = icnt;
    rcnt_nxt    = rcnt;
    bank_nxt    = bank;
    pending_nxt = pending || Refresh;
    case (state)
      IDLE: begin
        if (pending) begin
          state_nxt   = REFRESH;
          icnt_nxt    = '0;
          rcnt_nxt    = '0;
          pending_nxt = 1'b0;
        end else if (icnt == CNT_LAST) begin
          icnt_nxt    = '0;
          pending_nxt = 1'b1;
        end else begin
          icnt_nxt = icnt + 1'b1;
        end
      end
      REFRESH: begin
        if (rcnt == RC_LAST) begin
          state_nxt = IDLE;
          bank_nxt  = bank + 1'b1;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      icnt    <= '0;
      rcnt    <= '0;
      pending <= 1'b0;
      bank    <= '0;
    end else begin
      state   <= state_nxt;
      icnt    <= icnt_nxt;
      rcnt    <= rcnt_nxt;
      pending <= pending_nxt;
      bank    <= bank_nxt;
    end
  end

  // The storage array has no reset. A write with Read also set still writes.
  always_ff @(posedge Clock) begin
    if (do_wr) mem[Address] <= DataIn;
  end

  // Stage p1: registered read data and status pulses.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      vld_p1 <= do_rd;
      err_p1 <= illegal;
      if (do_rd) rdata_p1 <= mem[Address];
    end
  end

  assign DataOut   = rdata_p1;
  assign ReadValid = vld_p1;
  assign CmdError  = err_p1;

endmodule

// File: tb/tb_sdr_qsram_banked.sv
// Directed bench for sdr_qsram_banked: a scoreboard queue holds the expected read data,
// and a negedge monitor pops one entry for each ReadValid pulse.
module tb_sdr_qsram_banked;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int BB = 2;
  localparam int RI = 64;
  localparam int RC = 4;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          Enable = 1'b0;
  logic          Read = 1'b0;
  logic          Write = 1'b0;
  logic          Refresh = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] DataIn = '0;
  logic [DW-1:0] DataOut;
  logic          ReadValid;
  logic          Ready;
  logic          Refreshing;
  logic [BB-1:0] RefreshBank;
  logic          CmdError;

  sdr_qsram_banked #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_BITS(BB),
    .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Read(Read), .Write(Write),
    .Refresh(Refresh), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
    .ReadValid(ReadValid), .Ready(Ready), .Refreshing(Refreshing),
    .RefreshBank(RefreshBank), .CmdError(CmdError)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t  sb[$];
  rd_t  mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  int   ref_cyc = 0;
  int   ref_rises = 0;
  logic ref_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    if (ResetN) begin
      if (ReadValid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected", 32'(ReadValid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rd_data", 32'(DataOut), 32'(mon_e.data));
          chk("rd_latency", cyc, mon_e.due);
        end
      end
      if (CmdError) err_seen++;
      if (Refreshing) ref_cyc++;
      if (Refreshing && !ref_prev) ref_rises++;
    end
    ref_prev = Refreshing;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Enable = 1'b0;
    Read   = 1'b0;
    Write  = 1'b0;
  endtask

  // The command is held until a negedge shows Ready. The task returns 1 time unit after the accepting edge.
  task automatic cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic expect_rd,
                     input logic [DW-1:0] exp, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    Enable = 1'b1; Read = rd; Write = wr; Address = a; DataIn = d;
    while (!acc && waits < 40) begin
      @(negedge Clock);
      if (Ready) begin
        acc = 1'b1;
        if (expect_rd) sb.push_back('{exp, cyc + 1});
        if (rd == wr) err_exp++;
      end
      @(posedge Clock);
      #1;
      if (!acc) waits++;
    end
    if (!acc) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w;
    cmd(1'b0, 1'b1, a, d, 1'b0, '0, w);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int w;
    cmd(1'b1, 1'b0, a, '0, 1'b1, exp, w);
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    idle();
    Refresh = 1'b0;
    ResetN  = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int base_c;
    int base_r;
    int e;

    #2;
    chk("rst_dataout", 32'(DataOut), 32'd0);
    chk("rst_readvalid", 32'(ReadValid), 32'd0);
    chk("rst_cmderror", 32'(CmdError), 32'd0);
    chk("rst_refreshing", 32'(Refreshing), 32'd0);
    chk("rst_refreshbank", 32'(RefreshBank), 32'd0);
    chk("rst_ready", 32'(Ready), 32'd1);
    @(negedge Clock);
    ResetN = 1'b1;
    tick(1);

    // Back-to-back write then read of the same word.
    wr(8'h10, 16'hA5A5);
    rd(8'h10, 16'hA5A5);
    wr(8'h11, 16'h0F0F);
    rd(8'h11, 16'h0F0F);
    wr(8'h90, 16'hC3C3);
    rd(8'h90, 16'hC3C3);
    rd(8'h11, 16'h0F0F);
    idle();
    tick(3);
    chk("dout_hold", 32'(DataOut), 32'h0F0F);
    chk("dout_hold_valid", 32'(ReadValid), 32'd0);

    // Read and Write both set: the write happens and CmdError pulses.
    cmd(1'b1, 1'b1, 8'h05, 16'h1234, 1'b0, '0, w);
    chk("both_cmderr", 32'(CmdError), 32'd1);
    chk("both_no_valid", 32'(ReadValid), 32'd0);
    idle();
    tick(1);
    chk("cmderr_one_cycle", 32'(CmdError), 32'd0);
    rd(8'h05, 16'h1234);

    // Neither Read nor Write set: an error pulse with no storage change.
    cmd(1'b0, 1'b0, 8'h10, 16'hFFFF, 1'b0, '0, w);
    chk("none_cmderr", 32'(CmdError), 32'd1);
    idle();
    rd(8'h10, 16'hA5A5);
    idle();

    // Manual refresh of bank 0 while bank 1 keeps working.
    do_reset();
    tick(2);
    base_c = ref_cyc;
    base_r = ref_rises;
    Refresh = 1'b1;
    tick(1);
    Refresh = 1'b0;
    tick(1);
    Address = 8'h10;
    #1;
    chk("rf_active", 32'(Refreshing), 32'd1);
    chk("rf_bank0_ready", 32'(Ready), 32'd0);
    chk("rf_bank_during", 32'(RefreshBank), 32'd0);
    cmd(1'b0, 1'b1, 8'h50, 16'hBEEF, 1'b0, '0, w);
    chk("rf_bank1_wait", w, 0);
    rd(8'h50, 16'hBEEF);
    cmd(1'b0, 1'b1, 8'h20, 16'h7777, 1'b0, '0, w);
    chk("rf_bank0_stall", w, 2);
    idle();
    tick(8);
    chk("rf_len", ref_cyc - base_c, RC);
    chk("rf_rises", ref_rises - base_r, 1);
    chk("rf_bank_after", 32'(RefreshBank), 32'd1);
    rd(8'h20, 16'h7777);
    idle();

    // Four back-to-back manual refreshes rotate through all banks.
    do_reset();
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("bank_seq", 32'(RefreshBank), 32'(i));
      Refresh = 1'b1;
      tick(1);
      Refresh = 1'b0;
      tick(1);
      chk("bank_seq_busy", 32'(Refreshing), 32'd1);
      tick(6);
    end
    chk("bank_seq_wrap", 32'(RefreshBank), 32'd0);

    // Pulses during a refresh merge into exactly one follow-up refresh.
    do_reset();
    tick(1);
    base_c = ref_cyc;
    base_r = ref_rises;
    Refresh = 1'b1;
    tick(1);
    Refresh = 1'b0;
    tick(1);
    tick(1);
    Refresh = 1'b1;
    tick(1);
    Refresh = 1'b0;
    tick(1);
    Refresh = 1'b1;
    tick(1);
    Refresh = 1'b0;
    chk("merge_idle_gap", 32'(Refreshing), 32'd0);
    tick(1);
    chk("merge_second", 32'(Refreshing), 32'd1);
    tick(20);
    chk("merge_rises", ref_rises - base_r, 2);
    chk("merge_len", ref_cyc - base_c, 2 * RC);

    // Reset during a refresh, with a read in flight.
    do_reset();
    tick(1);
    Refresh = 1'b1;
    tick(1);
    Refresh = 1'b0;
    tick(1);
    cmd(1'b1, 1'b0, 8'h50, '0, 1'b0, '0, w);
    idle();
    chk("abort_pre_valid", 32'(ReadValid), 32'd1);
    chk("abort_pre_data", 32'(DataOut), 32'hBEEF);
    ResetN = 1'b0;
    #1;
    chk("abort_dataout", 32'(DataOut), 32'd0);
    chk("abort_readvalid", 32'(ReadValid), 32'd0);
    chk("abort_cmderror", 32'(CmdError), 32'd0);
    chk("abort_refreshing", 32'(Refreshing), 32'd0);
    chk("abort_refreshbank", 32'(RefreshBank), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    tick(5);

    // Timing of the first automatic refresh after reset release.
    do_reset();
    e = 0;
    while (e < 200) begin
      @(posedge Clock);
      e++;
      #1;
      if (Refreshing) break;
    end
    chk("first_auto_refresh", e, RI + 1);
    chk("first_auto_bank", 32'(RefreshBank), 32'd0);

    // Storage survives refreshes and resets.
    rd(8'h10, 16'hA5A5);
    rd(8'h05, 16'h1234);
    rd(8'h50, 16'hBEEF);
    rd(8'h90, 16'hC3C3);
    rd(8'h11, 16'h0F0F);
    idle();
    tick(4);
    chk("sb_drained", sb.size(), 0);
    chk("cmderr_count", err_seen, err_exp);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
